// File: rtl/serializer_pkg.sv
// Shared state encoding and helpers for the serializer sequence controller.
package serializer_pkg;

    localparam int STATE_W = 5;

    // One-hot state encoding: exactly one bit set per state.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 5'b00001,
        S_RESET = 5'b00010,
        S_GAP   = 5'b00100,
        S_TRIG  = 5'b01000,
        S_HOLD  = 5'b10000
    } state_e;

    // A programmed length or repeat count of zero behaves like one.
    function automatic logic [31:0] len_or_one(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/serializer_seq_ctrl_if.sv
// Host-side trigger/config/status bundle of the serializer sequence controller.
interface serializer_seq_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int REP_W  = 4
);
    logic              trigger_in;
    logic              abort;
    logic [CNT_W-1:0]  cfg_rst_len;
    logic [CNT_W-1:0]  cfg_gap_len;
    logic [CNT_W-1:0]  cfg_trig_len;
    logic [REP_W-1:0]  cfg_repeat;
    logic [NUM_CH-1:0] cfg_ch_mask;
    logic              reset_out;
    logic [NUM_CH-1:0] trigger_out;
    logic              busy;
    logic              done;

    modport master (
        output trigger_in, abort, cfg_rst_len, cfg_gap_len, cfg_trig_len,
               cfg_repeat, cfg_ch_mask,
        input  reset_out, trigger_out, busy, done
    );

    modport slave (
        input  trigger_in, abort, cfg_rst_len, cfg_gap_len, cfg_trig_len,
               cfg_repeat, cfg_ch_mask,
        output reset_out, trigger_out, busy, done
    );
endinterface

// File: rtl/serializer_phase_cnt.sv
// Phase-length down-counter; reloaded on every phase entry, last flags the final cycle.
module serializer_phase_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == '0);
endmodule

// File: rtl/serializer_seq_ctrl.sv
// Trigger-started reset/gap/burst sequencer driving a masked serializer trigger bus.
module serializer_seq_ctrl
    import serializer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int REP_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serializer_seq_ctrl_if.slave  bus
);
    state_e            state, state_n;
    logic              trig_d;
    logic              start;
    logic [CNT_W-1:0]  gap_len_q, trig_len_q;
    logic [REP_W-1:0]  rep_left;
    logic [NUM_CH-1:0] mask_q;
    logic              cnt_load, cnt_en, cnt_last;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              run_done;
    logic              reset_q, busy_q, done_q;
    logic [NUM_CH-1:0] trig_q;

    assign start = bus.trigger_in & ~trig_d;

    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
        return CNT_W'(len_or_one(32'(len)) - 32'd1);
    endfunction

    serializer_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .last     (cnt_last)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n      = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        run_done     = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_n      = S_RESET;
                cnt_load     = 1'b1;
                cnt_load_val = phase_load(bus.cfg_rst_len);
            end
            S_RESET: if (cnt_last) begin
                state_n      = S_GAP;
                cnt_load     = 1'b1;
                cnt_load_val = phase_load(gap_len_q);
            end
            S_GAP: if (cnt_last) begin
                state_n      = S_TRIG;
                cnt_load     = 1'b1;
                cnt_load_val = phase_load(trig_len_q);
            end
            S_TRIG: if (cnt_last) begin
                if (rep_left > REP_W'(1)) begin
                    state_n      = S_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = phase_load(gap_len_q);
                end else begin
                    state_n  = S_HOLD;
                    run_done = 1'b1;
                end
            end
            S_HOLD: if (!bus.trigger_in) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Abort wins over any transition and suppresses the completion pulse.
        if (bus.abort) begin
            state_n  = S_IDLE;
            cnt_load = 1'b0;
            run_done = 1'b0;
        end
    end

    assign cnt_en = (state == S_RESET) || (state == S_GAP) || (state == S_TRIG);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            trig_d     <= 1'b1;
            gap_len_q  <= '0;
            trig_len_q <= '0;
            rep_left   <= '0;
            mask_q     <= '0;
            reset_q    <= 1'b0;
            trig_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_n;
            trig_d <= bus.trigger_in;
            if (state == S_IDLE && state_n == S_RESET) begin
                gap_len_q  <= bus.cfg_gap_len;
                trig_len_q <= bus.cfg_trig_len;
                rep_left   <= REP_W'(len_or_one(32'(bus.cfg_repeat)));
                mask_q     <= bus.cfg_ch_mask;
            end else if (state == S_TRIG && cnt_last) begin
                rep_left <= rep_left - REP_W'(1);
            end
            // Outputs decode the next state so they line up with the state they describe.
            reset_q <= (state_n == S_RESET);
            trig_q  <= (state_n == S_TRIG) ? mask_q : '0;
            busy_q  <= (state_n != S_IDLE);
            done_q  <= run_done;
        end
    end

    assign bus.reset_out   = reset_q;
    assign bus.trigger_out = trig_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_serializer_seq_ctrl.sv
// Directed and randomized checks of serializer_seq_ctrl against a cycle-list reference model.
module tb_serializer_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serializer_seq_ctrl_if #(.NUM_CH(4), .CNT_W(8), .REP_W(4)) bus ();

    serializer_seq_ctrl #(.NUM_CH(4), .CNT_W(8), .REP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Observed vector layout: {busy, reset_out, trigger_out[3:0], done}
    function automatic logic [6:0] observed();
        return {bus.busy, bus.reset_out, bus.trigger_out, bus.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One run: the model lists, per cycle after the start edge, what the outputs must be.
    task automatic run(input string name, input int rl, input int gl, input int tl,
                       input int rep, input logic [3:0] mask, input int abort_at,
                       input int rst_at, input int toggle_at, input bit scramble);
        logic [6:0] exp_q[$];
        int r  = (rl  == 0) ? 1 : rl;
        int g  = (gl  == 0) ? 1 : gl;
        int t  = (tl  == 0) ? 1 : tl;
        int rp = (rep == 0) ? 1 : rep;
        bit stopped = 0;
        for (int i = 0; i < r; i++) exp_q.push_back(7'b1_1_0000_0);
        for (int k = 0; k < rp; k++) begin
            for (int i = 0; i < g; i++) exp_q.push_back(7'b1_0_0000_0);
            for (int i = 0; i < t; i++) exp_q.push_back({2'b10, mask, 1'b0});
        end
        exp_q.push_back(7'b1_0_0000_1);
        exp_q.push_back(7'b1_0_0000_0);
        exp_q.push_back(7'b1_0_0000_0);

        bus.cfg_rst_len  = 8'(rl);
        bus.cfg_gap_len  = 8'(gl);
        bus.cfg_trig_len = 8'(tl);
        bus.cfg_repeat   = 4'(rep);
        bus.cfg_ch_mask  = mask;
        bus.trigger_in   = 1'b0;
        step();
        check($sformatf("%s idle_before", name), observed(), 7'b0);
        bus.trigger_in = 1'b1;
        for (int i = 1; i <= exp_q.size(); i++) begin
            step();
            bus.abort = 1'b0;
            rst_n     = 1'b1;
            check($sformatf("%s cycle%0d", name, i), observed(), stopped ? 7'b0 : exp_q[i-1]);
            if (scramble && i == 1) begin
                bus.cfg_rst_len  = 8'($urandom_range(0, 9));
                bus.cfg_gap_len  = 8'($urandom_range(0, 9));
                bus.cfg_trig_len = 8'($urandom_range(0, 9));
                bus.cfg_repeat   = 4'($urandom_range(0, 9));
                bus.cfg_ch_mask  = 4'($urandom);
            end
            if (i == toggle_at)     bus.trigger_in = 1'b0;
            if (i == toggle_at + 1) bus.trigger_in = 1'b1;
            if (i == abort_at) begin bus.abort = 1'b1; stopped = 1; end
            if (i == rst_at)   begin rst_n = 1'b0;     stopped = 1; end
        end
        bus.trigger_in = 1'b0;
        step();
        check($sformatf("%s idle_after", name), observed(), 7'b0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.trigger_in   = 1'b1;
        bus.abort        = 1'b0;
        bus.cfg_rst_len  = 8'd2;
        bus.cfg_gap_len  = 8'd2;
        bus.cfg_trig_len = 8'd2;
        bus.cfg_repeat   = 4'd1;
        bus.cfg_ch_mask  = 4'hf;
        repeat (3) step();
        check("in_reset", observed(), 7'b0);

        // trigger_in held high across reset release: no run may start
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("no_start_after_reset%0d", i), observed(), 7'b0);
        end

        run("t1",    2, 3, 1, 1, 4'b0101, 0, 0, 0, 0);
        run("t2",    1, 2, 2, 3, 4'b1111, 0, 0, 0, 0);
        run("t3",    0, 0, 0, 0, 4'b1010, 0, 0, 0, 0);
        run("abort", 1, 2, 2, 3, 4'b1111, 5, 0, 0, 0);
        run("after_abort", 1, 2, 2, 3, 4'b1111, 0, 0, 0, 0);
        run("toggle_busy", 2, 1, 3, 2, 4'b0011, 0, 0, 3, 1);
        run("mask0", 3, 2, 2, 2, 4'b0000, 0, 0, 0, 0);
        run("rst_trig", 1, 1, 4, 2, 4'b1100, 0, 4, 0, 0);
        run("after_rst", 1, 1, 1, 1, 4'b0110, 0, 0, 0, 0);

        // Reset with trigger_in low, raised at release: trig_d=1 must block the edge
        bus.trigger_in = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.trigger_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_blocks_edge%0d", i), observed(), 7'b0);
        end

        for (int n = 0; n < 25; n++) begin
            int rl  = $urandom_range(0, 4);
            int gl  = $urandom_range(0, 4);
            int tl  = $urandom_range(0, 4);
            int rep = $urandom_range(0, 4);
            int tog = ($urandom_range(0, 1) == 1) ? 2 : 0;
            int ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
            run($sformatf("rand%0d", n), rl, gl, tl, rep, 4'($urandom), ab, 0, tog, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
